// File: rtl/absdiff_pkg.sv
// Shared types and widths for the absdiff datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package absdiff_pkg;

  // Block controller states: collecting pairs, or holding a finished result.
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int OPND_W = 4;  // operand width
  localparam int SUM_W  = 8;  // block sum width (max 15 * 16 = 240)
  localparam int GTC_W  = 5;  // greater-than count width (0..16)
  localparam int CNT_W  = 4;  // pairs-accepted counter width (0..15)

endpackage

// File: rtl/absdiff_unit_4b.sv
// Absolute difference of two 4-bit unsigned operands plus the in0 > in1 flag.
// Latency: combinational.
// Backpressure: none (pure logic).
// Ports: in0, in1 (operands) -> gt (in0 > in1), diff (|in0 - in1|).
module absdiff_unit_4b
  import absdiff_pkg::*;
(
  input  logic [OPND_W-1:0] in0,
  input  logic [OPND_W-1:0] in1,
  output logic              gt,
  output logic [OPND_W-1:0] diff
);

  logic [OPND_W-1:0] sub_ab;
  logic [OPND_W-1:0] sub_ba;

  gt_cmp_4b u_gt_cmp (
    .a  (in0),
    .b  (in1),
    .gt (gt)
  );

  // Both directions are computed; the comparator picks the one that cannot
  // wrap. Equal operands take the in1 - in0 leg, which is also zero.
  assign sub_ab = in0 - in1;
  assign sub_ba = in1 - in0;
  assign diff   = gt ? sub_ab : sub_ba;

endmodule

// File: rtl/gt_cmp_4b.sv
// 4-bit unsigned greater-than comparator.
// Latency: combinational.
// Backpressure: none (pure logic).
// Ports: a, b (operands) -> gt = (a > b).
module gt_cmp_4b
  import absdiff_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic              gt
);

  assign gt = (a > b);

endmodule

// File: rtl/sad_accum_4b.sv
// Streaming SAD engine: sums |in0 - in1| over NUM_PAIRS pairs and counts in0 > in1.
// Latency: result valid the cycle after the edge that accepts the last pair.
// Backpressure: in_rdy drops while a result waits; result held until out_rdy.
// Ports: clk, rst_n (sync, active-low); in_val/in_rdy/in0/in1 operand stream;
//        out_val/out_rdy/out_sum/out_gt_cnt block result stream.
module sad_accum_4b
  import absdiff_pkg::*;
#(
  parameter int NUM_PAIRS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [OPND_W-1:0] in0,
  input  logic [OPND_W-1:0] in1,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [SUM_W-1:0]  out_sum,
  output logic [GTC_W-1:0]  out_gt_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PAIRS - 1);

  state_t            state, state_nxt;
  logic [SUM_W-1:0]  acc, acc_nxt;
  logic [GTC_W-1:0]  gtc, gtc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              gt;
  logic [OPND_W-1:0] diff;
  logic              in_fire;
  logic              out_fire;

  absdiff_unit_4b u_absdiff (
    .in0  (in0),
    .in1  (in1),
    .gt   (gt),
    .diff (diff)
  );

  // Ready depends only on state and reset, never on in_val, so upstream can
  // compute valid from ready without a loop.
  assign in_rdy   = rst_n && (state == ACCUM);
  assign out_val  = (state == DONE);
  assign in_fire  = in_val && in_rdy;
  assign out_fire = out_val && out_rdy;

  // Result ports are zero outside DONE so nothing stale leaks downstream.
  assign out_sum    = (state == DONE) ? acc : '0;
  assign out_gt_cnt = (state == DONE) ? gtc : '0;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    gtc_nxt   = gtc;
    cnt_nxt   = cnt;
    case (state)
      ACCUM: begin
        if (in_fire) begin
          acc_nxt = acc + {{(SUM_W-OPND_W){1'b0}}, diff};
          gtc_nxt = gtc + {{(GTC_W-1){1'b0}}, gt};
          // Wraps to 0 on the 16th pair; cleared on out_fire regardless.
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_fire) begin
          acc_nxt   = '0;
          gtc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = ACCUM;
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      gtc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      gtc   <= gtc_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule
